// File: rtl/kyber_pkg.sv
// Kyber/ML-KEM constants, the PQClean zeta table and C-exact modular reductions
// shared by the NTT-domain blocks.
package kyber_pkg;

  localparam int KYBER_Q   = 3329;
  localparam int QINV      = -3327;
  localparam int BARRETT_V = 20159;
  localparam logic signed [15:0] INVNTT_F = 16'sd1441;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_BFLY  = 2'd1;
  localparam state_t ST_SCALE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam int ZETAS [0:127] = '{
    -1044,  -758,  -359, -1517,  1493,  1422,   287,   202,
     -171,   622,  1577,   182,   962, -1202, -1474,  1468,
      573, -1325,   264,   383,  -829,  1458, -1602,  -130,
     -681,  1017,   732,   608, -1542,   411,  -205, -1571,
     1223,   652,  -552,  1015, -1293,  1491,  -282, -1544,
      516,    -8,  -320,  -666, -1618, -1162,   126,  1469,
     -853,   -90,  -271,   830,   107, -1421,  -247,  -951,
     -398,   961, -1508,  -725,   448, -1065,   677, -1275,
    -1103,   430,   555,   843, -1251,   871,  1550,   105,
      422,   587,   177,  -235,  -291,  -460,  1574,  1653,
     -246,   778,  1159,  -147,  -777,  1483,  -602,  1119,
    -1590,   644,  -872,   349,   418,   329,  -156,   -75,
      817,  1097,   603,   610,  1322, -1285, -1465,   384,
    -1215,  -136,  1218, -1335,  -874,   220, -1187, -1659,
    -1185, -1530, -1278,   794, -1510,  -854,  -870,   478,
     -108,  -308,   996,   991,   958, -1460,  1522,  1628
  };

  // (a - m*q) has its low 16 bits cleared by construction, so the upper half is the result
  function automatic logic signed [15:0] montgomery_reduce(input logic signed [31:0] a);
    logic [31:0]        p;
    logic signed [15:0] m;
    logic signed [31:0] t;
    p = a * QINV;
    m = p[15:0];
    t = a - m * KYBER_Q;
    return t[31:16];
  endfunction

  function automatic logic signed [15:0] barrett_reduce(input logic signed [15:0] a);
    int                 t;
    logic signed [31:0] r;
    t = (BARRETT_V * a + (1 << 25)) >>> 26;
    r = a - t * KYBER_Q;
    return r[15:0];
  endfunction

endpackage

// File: rtl/gs_butterfly.sv
// Combinational Gentleman-Sande butterfly: r_j = barrett(t+u), r_jlen = fqmul(zeta, u-t).
// With t=0 the r_jlen path is a plain fqmul(zeta, u), which the scaling step reuses.
module gs_butterfly
  import kyber_pkg::*;
(
  input  logic signed [15:0] t,
  input  logic signed [15:0] u,
  input  logic signed [15:0] zeta,
  output logic signed [15:0] r_j,
  output logic signed [15:0] r_jlen
);

  // 16-bit sum/difference give exactly the int16 wrap the C code stores
  logic signed [15:0] sum;
  logic signed [15:0] diff;
  logic signed [31:0] prod;

  assign sum    = t + u;
  assign diff   = u - t;
  assign prod   = zeta * diff;
  assign r_j    = barrett_reduce(sum);
  assign r_jlen = montgomery_reduce(prod);

endmodule

// File: rtl/invntt.sv
// Iterative Kyber inverse NTT, one butterfly or scaling multiply per cycle.
// Define INVNTT_SCALE_EN to include the final multiply by f = 1441.
module invntt
  import kyber_pkg::*;
#(
  parameter int N = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [15:0] r_in  [0:N-1],
  output logic               done,
  output logic signed [15:0] r_out [0:N-1]
);

  state_t             state_reg;
  logic [2:0]         layer_reg;
  logic [6:0]         b_reg;
  logic [6:0]         k_reg;
  logic               done_reg;
  logic signed [15:0] rf [0:N-1];
`ifdef INVNTT_SCALE_EN
  logic [7:0]         idx_reg;
`endif

  logic [7:0]         len;
  logic [7:0]         mask;
  logic [7:0]         b_ext;
  logic [7:0]         j;
  logic [7:0]         j_len;
  logic [7:0]         rd_b;
  logic               grp_end;
  logic               last_b;
  logic               in_scale;
  logic               capture;
  logic               we_a;
  logic               we_b;
  logic signed [15:0] bf_t;
  logic signed [15:0] bf_u;
  logic signed [15:0] bf_zeta;
  logic signed [15:0] bf_rj;
  logic signed [15:0] bf_rjlen;

  // j = (b/len)*2len + b%len; bit log2(len) of j is always 0, so j+len is an OR
  assign len     = 8'd2 << layer_reg;
  assign mask    = len - 8'd1;
  assign b_ext   = {1'b0, b_reg};
  assign j       = ((b_ext & ~mask) << 1) | (b_ext & mask);
  assign j_len   = j | len;
  assign grp_end = (b_ext & mask) == mask;
  assign last_b  = b_reg == 7'd127;

`ifdef INVNTT_SCALE_EN
  assign in_scale = state_reg == ST_SCALE;
  assign rd_b     = in_scale ? idx_reg : j_len;
`else
  assign in_scale = 1'b0;
  assign rd_b     = j_len;
`endif

  assign capture = start && (state_reg == ST_IDLE || state_reg == ST_DONE);
  assign we_a    = state_reg == ST_BFLY;
  assign we_b    = we_a || in_scale;

  assign bf_t    = in_scale ? 16'sd0 : rf[j];
  assign bf_u    = rf[rd_b];
  assign bf_zeta = in_scale ? INVNTT_F : 16'(ZETAS[k_reg]);

  gs_butterfly u_bfly (
    .t      (bf_t),
    .u      (bf_u),
    .zeta   (bf_zeta),
    .r_j    (bf_rj),
    .r_jlen (bf_rjlen)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) rf[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < N; i++) rf[i] <= r_in[i];
    end else begin
      if (we_a) rf[j]    <= bf_rj;
      if (we_b) rf[rd_b] <= bf_rjlen;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      layer_reg <= '0;
      b_reg     <= '0;
      k_reg     <= 7'd127;
      done_reg  <= 1'b0;
`ifdef INVNTT_SCALE_EN
      idx_reg   <= '0;
`endif
    end else begin
      case (state_reg)
        ST_BFLY: begin
          b_reg <= b_reg + 7'd1;
          if (grp_end) k_reg <= k_reg - 7'd1;
          if (last_b) begin
            if (layer_reg == 3'd6) begin
`ifdef INVNTT_SCALE_EN
              state_reg <= ST_SCALE;
              idx_reg   <= '0;
`else
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
`endif
            end else begin
              layer_reg <= layer_reg + 3'd1;
            end
          end
        end
`ifdef INVNTT_SCALE_EN
        ST_SCALE: begin
          idx_reg <= idx_reg + 8'd1;
          if (idx_reg == 8'd255) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end
        end
`endif
        default: begin
          if (capture) begin
            state_reg <= ST_BFLY;
            layer_reg <= '0;
            b_reg     <= '0;
            k_reg     <= 7'd127;
            done_reg  <= 1'b0;
`ifdef INVNTT_SCALE_EN
            idx_reg   <= '0;
`endif
          end
        end
      endcase
    end
  end

  assign done = done_reg;

  for (genvar gi = 0; gi < N; gi++) begin : g_out
    assign r_out[gi] = rf[gi];
  end

endmodule

// File: tb/tb_invntt.sv
// Directed self-checking bench for invntt; reference is a C-style loop model plus
// round-trip congruence against a forward NTT model.
module tb_invntt;
  import kyber_pkg::ZETAS;

  localparam int Q = 3329;
`ifdef INVNTT_SCALE_EN
  localparam int LAT       = 1152;
  localparam int RT_FACTOR = 2285;
`else
  localparam int LAT       = 896;
  localparam int RT_FACTOR = 128;
`endif

  logic               clk   = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               done;
  logic signed [15:0] r_in  [0:255];
  logic signed [15:0] r_out [0:255];

  int m [0:255];
  int n_vec = 0;
  int n_err = 0;

  invntt dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .r_in  (r_in),
    .done  (done),
    .r_out (r_out)
  );

  always #5 clk = ~clk;

  function automatic int w16(input int x);
    return int'(shortint'(x));
  endfunction

  function automatic int mred(input int a);
    int mm;
    mm = w16(a * (-3327));
    return (a - mm * 3329) >>> 16;
  endfunction

  function automatic int fqmul(input int a, input int b);
    return mred(w16(a) * w16(b));
  endfunction

  function automatic int barrett(input int a_in);
    int a, t;
    a = w16(a_in);
    t = (20159 * a + 33554432) >>> 26;
    return w16(a - t * 3329);
  endfunction

  task automatic chk(input string tag, input int idx, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[%0d]: observed %0d expected %0d", tag, idx, obs, exp);
    end
  endtask

  task automatic model_invntt();
    int k, zeta, t;
    k = 127;
    for (int len = 2; len <= 128; len <<= 1) begin
      for (int st = 0; st < 256; st += 2 * len) begin
        zeta = ZETAS[k];
        k--;
        for (int jj = st; jj < st + len; jj++) begin
          t          = m[jj];
          m[jj]      = barrett(t + m[jj+len]);
          m[jj+len]  = fqmul(zeta, w16(m[jj+len] - t));
        end
      end
    end
`ifdef INVNTT_SCALE_EN
    for (int jj = 0; jj < 256; jj++) m[jj] = fqmul(m[jj], 1441);
`endif
  endtask

  task automatic model_ntt();
    int k, zeta, t;
    k = 1;
    for (int len = 128; len >= 2; len >>= 1) begin
      for (int st = 0; st < 256; st += 2 * len) begin
        zeta = ZETAS[k];
        k++;
        for (int jj = st; jj < st + len; jj++) begin
          t         = fqmul(zeta, m[jj+len]);
          m[jj+len] = w16(m[jj] - t);
          m[jj]     = w16(m[jj] + t);
        end
      end
    end
    for (int jj = 0; jj < 256; jj++) m[jj] = barrett(m[jj]);
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 256; i++) begin
      r_in[i] = 16'(i);
      m[i]    = i;
    end
  endtask

  task automatic run_op(input string tag, input int pulse_at);
    int cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_done_clr"}, 0, int'(done), 0);
    cyc = 0;
    while (!done && cyc < 3000) begin
      if (cyc == pulse_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    chk({tag, "_latency"}, 0, cyc, LAT);
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < 256; i++) chk(tag, i, int'(r_out[i]), w16(m[i]));
  endtask

  initial begin
    int nz, obs_mod;
    for (int i = 0; i < 256; i++) r_in[i] = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", 0, int'(done), 0);
    chk("rst_rout", 0, int'(r_out[0]), 0);
    chk("rst_rout", 255, int'(r_out[255]), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ramp input
    load_ramp();
    model_invntt();
    run_op("ramp", -1);
    check_model("ramp");

    // all-zero input: output zero, done holds
    for (int i = 0; i < 256; i++) r_in[i] = '0;
    run_op("zero", -1);
    for (int i = 0; i < 256; i++) chk("zero", i, int'(r_out[i]), 0);
    repeat (20) @(posedge clk);
    #1;
    chk("zero_done_hold", 0, int'(done), 1);
    chk("zero_hold", 7, int'(r_out[7]), 0);

    // delta input, started from DONE
    for (int i = 0; i < 256; i++) begin
      r_in[i] = '0;
      m[i]    = 0;
    end
    r_in[0] = 16'sd1;
    m[0]    = 1;
    model_invntt();
    run_op("delta", -1);
    check_model("delta");

    // round trip through forward NTT
    for (int i = 0; i < 256; i++) m[i] = i;
    model_ntt();
    for (int i = 0; i < 256; i++) r_in[i] = 16'(m[i]);
    run_op("rtrip", -1);
    for (int i = 0; i < 256; i++) begin
      obs_mod = ((int'(r_out[i]) % Q) + Q) % Q;
      chk("rtrip", i, obs_mod, (i * RT_FACTOR) % Q);
    end

    // start pulsed mid-computation is ignored
    load_ramp();
    model_invntt();
    run_op("midstart", 100);
    check_model("midstart");

    // asynchronous reset mid-operation, then full re-run
    load_ramp();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (400) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_done", 0, int'(done), 0);
    nz = 0;
    for (int i = 0; i < 256; i++) if (r_out[i] !== 16'sd0) nz++;
    chk("arst_rout_nonzero", 0, nz, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_ramp();
    model_invntt();
    run_op("rerun", -1);
    check_model("rerun");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
